// File: rtl/lsu_mem_controller.sv
// Load/store sequencer: alignment check, byte-lane steering, req/gnt/rvalid handshake
// and load extension, holding the pipeline stalled until the access completes.
module lsu_mem_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        lsu_start_in,
  input  logic        is_store_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [3:0]  bus_wstrb_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_gnt_in,
  input  logic        bus_rvalid_in,
  input  logic [31:0] bus_rdata_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        err_out
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        err_q, err_d;

  logic        misaligned_w;
  logic        accept_w;
  logic [3:0]  strobe_w;
  logic [31:0] steer_w;
  logic [7:0]  lane_byte_w;
  logic [15:0] lane_half_w;
  logic [31:0] ext_w;

  always_comb begin
    misaligned_w = 1'b0;
    strobe_w     = 4'b0000;
    steer_w      = store_data_in;
    unique case (load_size_in)
      2'b00: begin
        strobe_w = 4'b0001 << addr_in[1:0];
        steer_w  = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        misaligned_w = addr_in[0];
        strobe_w     = 4'b0011 << {addr_in[1], 1'b0};
        steer_w      = {2{store_data_in[15:0]}};
      end
      2'b10: begin
        misaligned_w = (addr_in[1:0] != 2'b00);
        strobe_w     = 4'b1111;
      end
      default: misaligned_w = 1'b1;
    endcase
  end

  assign accept_w = (state_q == S_IDLE) && lsu_start_in && !misaligned_w;

  // Lane selection uses the captured address, not the live one.
  always_comb begin
    lane_byte_w = bus_rdata_in[{addr_q[1:0], 3'b000} +: 8];
    lane_half_w = bus_rdata_in[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   ext_w = {{24{~uns_q & lane_byte_w[7]}}, lane_byte_w};
      2'b01:   ext_w = {{16{~uns_q & lane_half_w[15]}}, lane_half_w};
      default: ext_w = bus_rdata_in;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lsu_start_in) begin
          if (misaligned_w) begin
            misaligned_d = 1'b1;
          end else begin
            store_d = is_store_in;
            size_d  = load_size_in;
            uns_d   = load_unsigned_in;
            addr_d  = addr_in;
            wstrb_d = is_store_in ? strobe_w : 4'b0000;
            wdata_d = steer_w;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt_in) begin
          state_d = store_q ? S_DONE : S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (bus_rvalid_in) begin
          load_data_d  = ext_w;
          load_valid_d = 1'b1;
          state_d      = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          load_data_d = 32'h0;
          err_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= 32'h0;
      wstrb_q      <= 4'b0000;
      wdata_q      <= 32'h0;
      cnt_q        <= '0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
      err_q        <= err_d;
    end
  end

  // Bus outputs are only driven while the request is outstanding.
  always_comb begin
    bus_req_out   = (state_q == S_REQ);
    bus_we_out    = bus_req_out & store_q;
    bus_addr_out  = bus_req_out ? {addr_q[31:2], 2'b00} : 32'h0;
    bus_wstrb_out = bus_req_out ? wstrb_q : 4'b0000;
    bus_wdata_out = bus_req_out ? wdata_q : 32'h0;
  end

  assign stall_out      = accept_w || (state_q == S_REQ) || (state_q == S_WAIT);
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign misaligned_out = misaligned_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Randomized and directed bench for lsu_mem_controller against an arithmetic
// reference model of alignment, strobes, lane steering and load extension.
module tb_lsu_mem_controller;

  localparam int TO = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        lsu_start_in;
  logic        is_store_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [3:0]  bus_wstrb_out;
  logic [31:0] bus_wdata_out;
  logic        bus_gnt_in;
  logic        bus_rvalid_in;
  logic [31:0] bus_rdata_in;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        misaligned_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  logic [31:0] exp_ld_q = 32'h0;

  lsu_mem_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .lsu_start_in(lsu_start_in),
    .is_store_in(is_store_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .addr_in(addr_in),
    .store_data_in(store_data_in), .bus_req_out(bus_req_out),
    .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
    .bus_wstrb_out(bus_wstrb_out), .bus_wdata_out(bus_wdata_out),
    .bus_gnt_in(bus_gnt_in), .bus_rvalid_in(bus_rvalid_in),
    .bus_rdata_in(bus_rdata_in), .stall_out(stall_out),
    .load_data_out(load_data_out), .load_valid_out(load_valid_out),
    .misaligned_out(misaligned_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn_no, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference model: access width in bytes is 2**size, offset is addr mod 4.
  function automatic bit m_misaligned(input int size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size == 3) return 1'b1;
    return (off % (1 << size)) != 0;
  endfunction

  function automatic logic [3:0] m_strobe(input bit st, input int size, input logic [31:0] addr);
    logic [3:0] s = 4'b0000;
    int off = int'(addr % 4);
    int n = 1 << size;
    if (!st) return 4'b0000;
    for (int k = 0; k < 4; k++) s[k] = (k >= off) && (k < off + n);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] d);
    logic [31:0] w = 32'h0;
    int n = 1 << size;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int size, input bit uns, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    longint v;
    longint span;
    int n = 1 << size;
    span = longint'(1) << (8 * n);
    v = longint'(rdata) >> (8 * (addr % 4));
    v = v % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(bus_req_out), 32'h0);
    check_eq({tag, "_stall"}, 32'(stall_out), 32'h0);
    check_eq({tag, "_lv"}, 32'(load_valid_out), 32'h0);
    check_eq({tag, "_err"}, 32'(err_out), 32'h0);
    check_eq({tag, "_mis"}, 32'(misaligned_out), 32'h0);
    check_eq({tag, "_ldata"}, load_data_out, exp_ld_q);
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input bit st, input int size, input bit uns, input logic [31:0] addr,
                         input logic [31:0] data, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata);
    bit mis = m_misaligned(size, addr);
    logic [31:0] exp_v;
    logic [31:0] size_v = 32'(size);
    txn_no++;
    $display("txn %0d store=%0d size=%0d uns=%0d addr=%h data=%h gnt_dly=%0d rv_dly=%0d rdata=%h",
             txn_no, st, size, uns, addr, data, gnt_dly, rv_dly, rdata);
    is_store_in = st; load_size_in = size_v[1:0]; load_unsigned_in = uns;
    addr_in = addr; store_data_in = data; lsu_start_in = 1'b1;
    #1;
    check_eq("stall_start", 32'(stall_out), 32'(!mis));
    tick();
    lsu_start_in = 1'b0; addr_in = $urandom; store_data_in = $urandom;
    load_size_in = 2'($urandom); is_store_in = 1'($urandom);
    #1;
    if (mis) begin
      check_eq("mis_pulse", 32'(misaligned_out), 32'h1);
      check_eq("mis_req", 32'(bus_req_out), 32'h0);
      check_eq("mis_stall", 32'(stall_out), 32'h0);
      tick(); #1;
      check_idle_outputs("mis_after");
      return;
    end
    check_eq("no_mis", 32'(misaligned_out), 32'h0);
    for (int i = 0; i <= gnt_dly; i++) begin
      bus_gnt_in = (i == gnt_dly);
      bus_rvalid_in = (i == gnt_dly);
      bus_rdata_in = $urandom;
      #1;
      check_eq("req", 32'(bus_req_out), 32'h1);
      check_eq("we", 32'(bus_we_out), 32'(st));
      check_eq("addr", bus_addr_out, {addr[31:2], 2'b00});
      check_eq("wstrb", 32'(bus_wstrb_out), 32'(m_strobe(st, size, addr)));
      if (st) check_eq("wdata", bus_wdata_out, m_wdata(size, data));
      check_eq("stall_req", 32'(stall_out), 32'h1);
      tick();
    end
    bus_gnt_in = 1'b0; bus_rvalid_in = 1'b0;
    #1;
    if (!st) begin
      if (rv_dly >= TO) begin
        for (int i = 0; i < TO; i++) begin
          check_eq("wait_stall", 32'(stall_out), 32'h1);
          check_eq("wait_req", 32'(bus_req_out), 32'h0);
          check_eq("wait_err", 32'(err_out), 32'h0);
          tick(); #1;
        end
        exp_ld_q = 32'h0;
        check_eq("to_err", 32'(err_out), 32'h1);
        check_eq("to_lv", 32'(load_valid_out), 32'h0);
        check_eq("to_ldata", load_data_out, 32'h0);
        check_eq("to_stall", 32'(stall_out), 32'h0);
      end else begin
        for (int i = 0; i < rv_dly; i++) begin
          check_eq("wait_stall", 32'(stall_out), 32'h1);
          check_eq("wait_req", 32'(bus_req_out), 32'h0);
          tick();
        end
        bus_rvalid_in = 1'b1; bus_rdata_in = rdata;
        #1;
        check_eq("rv_stall", 32'(stall_out), 32'h1);
        tick();
        bus_rvalid_in = 1'b0; bus_rdata_in = $urandom;
        #1;
        exp_v = m_load(size, uns, addr, rdata);
        exp_ld_q = exp_v;
        check_eq("ld_valid", 32'(load_valid_out), 32'h1);
        check_eq("ld_data", load_data_out, exp_v);
        check_eq("ld_err", 32'(err_out), 32'h0);
        check_eq("ld_stall", 32'(stall_out), 32'h0);
      end
    end else begin
      check_eq("st_done_req", 32'(bus_req_out), 32'h0);
      check_eq("st_done_stall", 32'(stall_out), 32'h0);
      check_eq("st_done_lv", 32'(load_valid_out), 32'h0);
    end
    tick(); #1;
    check_idle_outputs("idle");
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, 32'(bus_req_out), 32'h0);
    check_eq({tag, "_we"}, 32'(bus_we_out), 32'h0);
    check_eq({tag, "_addr"}, bus_addr_out, 32'h0);
    check_eq({tag, "_wstrb"}, 32'(bus_wstrb_out), 32'h0);
    check_eq({tag, "_wdata"}, bus_wdata_out, 32'h0);
    check_idle_outputs(tag);
  endtask

  initial begin
    rst_in = 1'b1; lsu_start_in = 1'b0; is_store_in = 1'b0; load_size_in = 2'b00;
    load_unsigned_in = 1'b0; addr_in = 32'h0; store_data_in = 32'h0;
    bus_gnt_in = 1'b0; bus_rvalid_in = 1'b0; bus_rdata_in = 32'h0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #1;
    check_all_zero("reset");

    run_txn(1'b1, 0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
    run_txn(1'b0, 1, 1'b0, 32'h0000_2002, 32'h0, 3, 2, 32'h8001_1234);
    run_txn(1'b0, 0, 1'b1, 32'h0000_0001, 32'h0, 0, 0, 32'h0000_F000);
    run_txn(1'b0, 2, 1'b0, 32'h0000_0006, 32'h0, 0, 0, 32'h0);
    run_txn(1'b1, 1, 1'b0, 32'h0000_0001, 32'h1234_5678, 0, 0, 32'h0);
    run_txn(1'b0, 2, 1'b0, 32'h0000_0040, 32'h0, 1, TO, 32'h0);

    // Reset while waiting for read data.
    txn_no++;
    $display("txn %0d reset during WAIT", txn_no);
    is_store_in = 1'b0; load_size_in = 2'b10; load_unsigned_in = 1'b0;
    addr_in = 32'h0000_0020; lsu_start_in = 1'b1;
    tick();
    lsu_start_in = 1'b0; bus_gnt_in = 1'b1;
    tick();
    bus_gnt_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    exp_ld_q = 32'h0;
    #1;
    check_all_zero("rst_wait");
    tick();
    run_txn(1'b0, 2, 1'b0, 32'h0000_0010, 32'h0, 0, 1, 32'hDEAD_BEEF);

    for (int n = 0; n < 60; n++) begin
      int rv = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 4));
      run_txn(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)), rv, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
